// File: rtl/sample_decimator_if.sv
// Sample stream interface for the decimator: the upstream side provides samples and
// control, and the decimator drives back the averaged result and its status.
interface sample_decimator_if #(
    parameter int D_WIDTH = 8
);
    logic               en;
    logic               din_valid;
    logic [D_WIDTH-1:0] din;
    logic [1:0]         decim_sel;
    logic [D_WIDTH-1:0] dout;
    logic               dout_valid;
    logic               busy;

    modport master (
        output en, din_valid, din, decim_sel,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  en, din_valid, din, decim_sel,
        output dout, dout_valid, busy
    );
endinterface

// File: rtl/sample_decimator.sv
// Boxcar decimator: averages windows of 1, 2, 4 or 8 accepted samples and emits
// one strobed result per window.
//
// state | meaning
// IDLE  | no partial window; N=1 samples pass straight through from here
// ACCUM | window started, waiting for the remaining samples
module sample_decimator #(
    parameter int D_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    sample_decimator_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state;
    logic [D_WIDTH+2:0] acc;
    logic [2:0]         cnt;
    logic [1:0]         n_sel;
    logic [D_WIDTH-1:0] dout_r;
    logic               dout_valid_r;

    logic [D_WIDTH+2:0] sum;
    logic [D_WIDTH-1:0] avg;
    logic [2:0]         cnt_load;

    assign sum = acc + {3'b000, bus.din};

    // Sum of N samples shifted by log2(N); the selected slice is always D_WIDTH wide.
    always_comb begin
        avg = sum[D_WIDTH-1:0];
        case (n_sel)
            2'd1:    avg = sum[D_WIDTH:1];
            2'd2:    avg = sum[D_WIDTH+1:2];
            2'd3:    avg = sum[D_WIDTH+2:3];
            default: avg = sum[D_WIDTH-1:0];
        endcase
    end

    // Down-counter preload: samples still to come after sample 0, minus one.
    always_comb begin
        cnt_load = 3'd0;
        case (bus.decim_sel)
            2'd1:    cnt_load = 3'd0;
            2'd2:    cnt_load = 3'd2;
            2'd3:    cnt_load = 3'd6;
            default: cnt_load = 3'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            n_sel        <= 2'd0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= 1'b0;
            if (!bus.en) begin
                state <= IDLE;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.din_valid) begin
                            n_sel <= bus.decim_sel;
                            if (bus.decim_sel == 2'd0) begin
                                dout_r       <= bus.din;
                                dout_valid_r <= 1'b1;
                            end else begin
                                acc   <= {3'b000, bus.din};
                                cnt   <= cnt_load;
                                state <= ACCUM;
                            end
                        end
                    end
                    ACCUM: begin
                        if (bus.din_valid) begin
                            if (cnt == 3'd0) begin
                                dout_r       <= avg;
                                dout_valid_r <= 1'b1;
                                acc          <= '0;
                                state        <= IDLE;
                            end else begin
                                acc <= sum;
                                cnt <= cnt - 3'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.busy       = (state == ACCUM);
endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator: a window-level reference model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_sample_decimator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;

    sample_decimator_if #(.D_WIDTH(8)) bus ();

    sample_decimator #(.D_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: collect the current window, average it once it is full.
    int       win[$];
    int       win_n = 1;
    int       exp_dout = 0;
    bit       exp_valid = 1'b0;
    bit       exp_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            win.delete();
            exp_dout  = 0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (!bus.en) begin
                win.delete();
            end else if (bus.din_valid) begin
                if (win.size() == 0) win_n = 1 << bus.decim_sel;
                win.push_back(int'(bus.din));
                if (win.size() == win_n) begin
                    int s;
                    s = 0;
                    foreach (win[i]) s += win[i];
                    exp_dout  = s / win_n;
                    exp_valid = 1'b1;
                    win.delete();
                end
            end
        end
        exp_busy = (win.size() != 0);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (int'(bus.dout) != exp_dout) begin
                errors++;
                $display("FAIL model_dout t=%0t actual=%0d expected=%0d", $time, bus.dout, exp_dout);
            end
            checks++;
            if (bus.dout_valid !== exp_valid) begin
                errors++;
                $display("FAIL model_valid t=%0t actual=%0b expected=%0b", $time, bus.dout_valid, exp_valid);
            end
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL model_busy t=%0t actual=%0b expected=%0b", $time, bus.busy, exp_busy);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int d, input int v, input int b);
        check({name, "_dout"}, int'(bus.dout), d);
        check({name, "_valid"}, int'(bus.dout_valid), v);
        check({name, "_busy"}, int'(bus.busy), b);
    endtask

    // Drive one clock cycle of inputs; returns 1 time unit after the edge that consumed them.
    task automatic cycle(input bit v, input int d);
        bus.din_valid = v;
        bus.din       = 8'(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.decim_sel = 2'd0;
        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0);
        rst = 1'b0;
        cycle(0, 0);
        check_out("post_reset", 0, 0, 0);

        // N=1 pass-through
        bus.en = 1'b1;
        bus.decim_sel = 2'd0;
        cycle(1, 37);
        check_out("n1_strobe", 37, 1, 0);
        cycle(0, 0);
        check_out("n1_after", 37, 0, 0);

        // N=4 basic window
        bus.decim_sel = 2'd2;
        cycle(1, 10);
        check_out("n4_s0", 37, 0, 1);
        cycle(1, 20);
        cycle(1, 30);
        check_out("n4_s2", 37, 0, 1);
        cycle(1, 40);
        check_out("n4_done", 25, 1, 0);
        cycle(0, 0);
        check_out("n4_after", 25, 0, 0);

        // N=8 full scale, then truncation
        bus.decim_sel = 2'd3;
        for (int i = 0; i < 8; i++) cycle(1, 255);
        check_out("n8_max", 255, 1, 0);
        for (int i = 0; i < 7; i++) cycle(1, 1);
        cycle(1, 2);
        check_out("n8_trunc", 1, 1, 0);

        // en drop discards a partial window
        bus.decim_sel = 2'd2;
        cycle(1, 100);
        cycle(1, 100);
        bus.en = 1'b0;
        cycle(0, 0);
        check_out("en_drop", 1, 0, 0);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1, 8);
        check_out("en_resume", 8, 1, 0);

        // decim_sel change mid-window, then back-to-back N=1
        bus.decim_sel = 2'd1;
        cycle(1, 6);
        bus.decim_sel = 2'd0;
        cycle(1, 8);
        check_out("sel_change", 7, 1, 0);
        cycle(1, 9);
        check_out("sel_next", 9, 1, 0);

        // back-to-back N=2 windows, no lost sample
        bus.decim_sel = 2'd1;
        cycle(1, 1);
        cycle(1, 3);
        check_out("b2b_w0", 2, 1, 0);
        cycle(1, 5);
        check_out("b2b_w1s0", 2, 0, 1);
        cycle(1, 7);
        check_out("b2b_w1", 6, 1, 0);

        // gaps inside a window leave state alone
        bus.decim_sel = 2'd2;
        cycle(1, 4);
        cycle(0, 99);
        cycle(1, 8);
        cycle(0, 99);
        cycle(0, 99);
        check_out("gap_hold", 6, 0, 1);
        cycle(1, 12);
        cycle(1, 16);
        check_out("gap_done", 10, 1, 0);

        // async reset mid-window
        cycle(1, 50);
        cycle(1, 60);
        #2 rst = 1'b1;
        #1 check_out("async_rst", 0, 0, 0);
        #2 rst = 1'b0;
        cycle(1, 70);
        check_out("rst_rel", 0, 0, 1);
        cycle(1, 80);
        cycle(1, 90);
        check_out("rst_partial", 0, 0, 1);
        cycle(1, 100);
        check_out("rst_window", 85, 1, 0);
        cycle(0, 0);
        check_out("final", 85, 0, 0);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_decimator.md
SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

Interface
REQ-001 Parameter D_WIDTH, default 8: sample width in bits, for both input and output.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  block enable; when low the block idles and any partial window is discarded.
REQ-005 din_valid  input  1  qualifies din for one cycle.
REQ-006 din  input  D_WIDTH  unsigned raw input sample.
REQ-007 decim_sel  input  2  window length N = 1, 2, 4, 8 for codes 0, 1, 2, 3.
REQ-008 dout  output  D_WIDTH  unsigned averaged sample, driven to the downstream delay stage's din.
REQ-009 dout_valid  output  1  one-cycle strobe for dout; drives the downstream write enable.
REQ-010 busy  output  1  high while a window is partially accumulated.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and ACCUM.
REQ-012 IDLE->ACCUM SHALL occur on the first cycle with en=1 and din_valid=1; that sample is accepted as window sample 0, and decim_sel is latched as window length N.
REQ-013 In ACCUM, each cycle with en=1 and din_valid=1 SHALL accept one sample; cycles with din_valid=0 SHALL leave all state unchanged.
REQ-014 The accumulator SHALL be D_WIDTH+3 bits wide, unsigned, and SHALL never overflow (8 x max sample fits).
REQ-015 On acceptance of sample N-1, dout SHALL be registered as (sum of the N samples) >> log2(N), truncating with no rounding.
REQ-016 On that same cycle, the accumulator and sample count SHALL clear.
REQ-017 dout_valid SHALL be high for exactly the one cycle following acceptance of sample N-1; latency is 1 clock.
REQ-018 After a window completes, the FSM SHALL return to IDLE; a valid sample arriving on the dout_valid cycle SHALL start a new window with no lost samples.
REQ-019 When N=1, every accepted sample SHALL appear unchanged on dout one cycle later, with dout_valid set; the FSM remains in IDLE.
REQ-020 A change of decim_sel during ACCUM SHALL NOT affect the current window; it applies from the next window start.
REQ-021 en=0 in any state SHALL force IDLE, clear the accumulator and count, and suppress dout_valid on the following cycle.
REQ-022 dout SHALL hold its last value between strobes, including while en=0.
REQ-023 busy SHALL equal (state==ACCUM).
REQ-024 At most one dout_valid SHALL be produced per N accepted samples; the strobe SHALL never be high on two consecutive cycles unless N=1.

Reset
REQ-025 While rst=1, independent of clk: state=IDLE, accumulator=0, count=0, latched N=1, dout=0, dout_valid=0, busy=0.
REQ-026 Reset asserted mid-window SHALL discard the partial window; the first valid sample after release SHALL start a new window.
REQ-027 Reset release SHALL be synchronous-safe: no strobe in the first cycle after deassertion.

Verification
REQ-028 decim_sel=0, en=1, din=37 valid for one cycle -> dout=37, dout_valid=1 on the next cycle only.
REQ-029 decim_sel=2, samples 10, 20, 30, 40 on consecutive cycles -> dout=25 one cycle after 40, single strobe, busy high for cycles 1-3.
REQ-030 decim_sel=3, eight samples of 255 -> dout=255 with no wrap; samples 0-6 =1 and 7 =2 -> dout=1 (truncation).
REQ-031 decim_sel=2, samples 100 and 100, then en=0 for one cycle, then 4 x 8 -> single strobe, dout=8; the partial window is discarded.
REQ-032 decim_sel switched from 1 to 0 after the first sample of a 2-window (samples 6, 8) -> dout=7; the next sample, 9, -> dout=9 immediately.
REQ-033 rst pulsed asynchronously between clock edges mid-window -> outputs are zero immediately; no dout_valid until a full new window completes.
